// File: rtl/tri_port_scheduler.sv
// Round-robin scheduler sharing one single-port SRAM between three request ports.
// Optional build macro RDATA_REG_EN registers the read response (2-cycle read latency instead of 1).
module tri_port_scheduler #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              halt,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   input  logic              p2_req,
   input  logic              p2_we,
   input  logic [ADDR_W-1:0] p2_addr,
   input  logic [DATA_W-1:0] p2_wdata,
   output logic              p2_gnt,
   output logic              p2_rvalid,
   output logic [DATA_W-1:0] p2_rdata,
   input  logic              p3_req,
   input  logic              p3_we,
   input  logic [ADDR_W-1:0] p3_addr,
   input  logic [DATA_W-1:0] p3_wdata,
   output logic              p3_gnt,
   output logic              p3_rvalid,
   output logic [DATA_W-1:0] p3_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {PORT_1 = 2'd0, PORT_2 = 2'd1, PORT_3 = 2'd2} port_e;

   logic [2:0]        req_v;
   logic [2:0]        we_v;
   logic [ADDR_W-1:0] addr_a  [3];
   logic [DATA_W-1:0] wdata_a [3];

   assign req_v      = {p3_req, p2_req, p1_req};
   assign we_v       = {p3_we, p2_we, p1_we};
   assign addr_a[0]  = p1_addr;
   assign addr_a[1]  = p2_addr;
   assign addr_a[2]  = p3_addr;
   assign wdata_a[0] = p1_wdata;
   assign wdata_a[1] = p2_wdata;
   assign wdata_a[2] = p3_wdata;

   port_e      last_grant_q, last_grant_d;
   port_e      sel;
   logic       found;
   logic [2:0] gnt;
   logic [1:0] idx;

   // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      sel   = last_grant_q;
      idx   = '0;
      // Search starts at the port after the last grant and wraps; halt masks every request.
      for (int k = 1; k <= 3; k++) begin
         idx = 2'((int'(last_grant_q) + k) % 3);
         if (!found && !halt && req_v[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            sel      = port_e'(idx);
         end
      end
   end

   assign p1_gnt = gnt[0];
   assign p2_gnt = gnt[1];
   assign p3_gnt = gnt[2];

   always_comb begin
      mem_en    = found;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (found) begin
         mem_we    = we_v[sel];
         mem_addr  = addr_a[sel];
         mem_wdata = wdata_a[sel];
      end
   end

   logic  resp_vld_q, resp_vld_d;
   port_e resp_port_q, resp_port_d;

   always_comb begin
      last_grant_d = found ? sel : last_grant_q;
      resp_vld_d   = found && !we_v[sel];
      resp_port_d  = sel;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= PORT_3;
         resp_vld_q   <= 1'b0;
         resp_port_q  <= PORT_1;
      end else begin
         last_grant_q <= last_grant_d;
         resp_vld_q   <= resp_vld_d;
         resp_port_q  <= resp_port_d;
      end
   end

   logic [2:0]        rvalid_v;
   logic [DATA_W-1:0] rdata_s;

`ifdef RDATA_REG_EN
   logic [2:0]        out_vld_q, out_vld_d;
   logic [DATA_W-1:0] out_rdata_q, out_rdata_d;

   // SRAM data is captured the cycle it arrives and presented one cycle later.
   always_comb begin
      out_vld_d   = '0;
      out_rdata_d = '0;
      if (resp_vld_q) begin
         out_vld_d[resp_port_q] = 1'b1;
         out_rdata_d            = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_vld_q   <= '0;
         out_rdata_q <= '0;
      end else begin
         out_vld_q   <= out_vld_d;
         out_rdata_q <= out_rdata_d;
      end
   end

   assign rvalid_v = out_vld_q;
   assign rdata_s  = out_rdata_q;
   assign busy     = (|req_v) | resp_vld_q | (|out_vld_q);
`else
   always_comb begin
      rvalid_v = '0;
      if (resp_vld_q) rvalid_v[resp_port_q] = 1'b1;
   end

   assign rdata_s = resp_vld_q ? mem_rdata : '0;
   assign busy    = (|req_v) | resp_vld_q;
`endif

   assign p1_rvalid = rvalid_v[0];
   assign p2_rvalid = rvalid_v[1];
   assign p3_rvalid = rvalid_v[2];
   assign p1_rdata  = rvalid_v[0] ? rdata_s : '0;
   assign p2_rdata  = rvalid_v[1] ? rdata_s : '0;
   assign p3_rdata  = rvalid_v[2] ? rdata_s : '0;

endmodule
